// File: rtl/complex_operand_packer_if.sv
// Handshake bundle for the complex operand packer: serial word input side and
// packed A/B/op output side, plus the frame-error status.
interface complex_operand_packer_if #(
    parameter int WORD_W = 32,
    parameter int ERR_W  = 8
);
    logic [WORD_W-1:0]   in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_op;
    logic                in_ready;
    logic [2*WORD_W-1:0] A;
    logic [2*WORD_W-1:0] B;
    logic                op;
    logic                out_valid;
    logic                out_ready;
    logic                frame_err;
    logic [ERR_W-1:0]    err_cnt;

    modport master (
        output in_data, in_valid, in_last, in_op, out_ready,
        input  in_ready, A, B, op, out_valid, frame_err, err_cnt
    );

    modport slave (
        input  in_data, in_valid, in_last, in_op, out_ready,
        output in_ready, A, B, op, out_valid, frame_err, err_cnt
    );
endinterface

// File: rtl/complex_operand_packer.sv
// Packs a serial stream of four words (A_real, A_imj, B_real, B_imj) into two
// complex operands and holds them under a valid/ready handshake.
module complex_operand_packer #(
    parameter int WORD_W = 32,
    parameter int ERR_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    complex_operand_packer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_AR   = 3'd0,
        S_AI   = 3'd1,
        S_BR   = 3'd2,
        S_BI   = 3'd3,
        S_HOLD = 3'd4,
        S_SKIP = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [2*WORD_W-1:0] a_r, a_s;
    logic [2*WORD_W-1:0] b_r, b_s;
    logic                op_r, op_s;
    logic                valid_r, valid_s;
    logic                frame_err_r, err_s;
    logic [ERR_W-1:0]    err_cnt_r, err_cnt_s;
    logic                in_ready_s;
    logic                xfer_s;

    // Ready follows the state register; forced low while reset is asserted.
    assign in_ready_s    = rst_n && (state_r != S_HOLD);
    assign xfer_s        = bus.in_valid && in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.A         = a_r;
    assign bus.B         = b_r;
    assign bus.op        = op_r;
    assign bus.out_valid = valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.err_cnt   = err_cnt_r;

    // Next-state, operand capture and framing-error detection.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        op_s    = op_r;
        valid_s = valid_r;
        err_s   = 1'b0;
        case (state_r)
            S_AR: begin
                if (xfer_s && bus.in_last) begin
                    err_s = 1'b1;
                end else if (xfer_s) begin
                    a_s[2*WORD_W-1:WORD_W] = bus.in_data;
                    op_s                   = bus.in_op;
                    state_s                = S_AI;
                end else begin
                    state_s = S_AR;
                end
            end
            S_AI: begin
                if (xfer_s && bus.in_last) begin
                    err_s   = 1'b1;
                    state_s = S_AR;
                end else if (xfer_s) begin
                    a_s[WORD_W-1:0] = bus.in_data;
                    state_s         = S_BR;
                end else begin
                    state_s = S_AI;
                end
            end
            S_BR: begin
                if (xfer_s && bus.in_last) begin
                    err_s   = 1'b1;
                    state_s = S_AR;
                end else if (xfer_s) begin
                    b_s[2*WORD_W-1:WORD_W] = bus.in_data;
                    state_s                = S_BI;
                end else begin
                    state_s = S_BR;
                end
            end
            S_BI: begin
                if (xfer_s && bus.in_last) begin
                    b_s[WORD_W-1:0] = bus.in_data;
                    valid_s         = 1'b1;
                    state_s         = S_HOLD;
                end else if (xfer_s) begin
                    // Frame too long: the remainder is swallowed in S_SKIP without recounting.
                    err_s   = 1'b1;
                    state_s = S_SKIP;
                end else begin
                    state_s = S_BI;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    valid_s = 1'b0;
                    state_s = S_AR;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_SKIP: begin
                if (xfer_s && bus.in_last) begin
                    state_s = S_AR;
                end else begin
                    state_s = S_SKIP;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = S_AR;
            end
        endcase
    end

    // Saturating dropped-frame counter.
    always_comb begin
        err_cnt_s = err_cnt_r;
        if (err_s && (err_cnt_r != {ERR_W{1'b1}})) begin
            err_cnt_s = err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_AR;
            a_r         <= {(2*WORD_W){1'b0}};
            b_r         <= {(2*WORD_W){1'b0}};
            op_r        <= 1'b0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            err_cnt_r   <= {ERR_W{1'b0}};
        end else begin
            state_r     <= state_s;
            a_r         <= a_s;
            b_r         <= b_s;
            op_r        <= op_s;
            valid_r     <= valid_s;
            frame_err_r <= err_s;
            err_cnt_r   <= err_cnt_s;
        end
    end
endmodule

// File: tb/tb_complex_operand_packer.sv
// Directed bench for complex_operand_packer; a second instance with a 2-bit
// error counter shares the stimulus to exercise counter saturation.
module tb_complex_operand_packer;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    complex_operand_packer_if #(.WORD_W(32), .ERR_W(8)) b1 ();
    complex_operand_packer_if #(.WORD_W(32), .ERR_W(2)) b2 ();

    complex_operand_packer #(.WORD_W(32), .ERR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(b1));
    complex_operand_packer #(.WORD_W(32), .ERR_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    assign b2.in_data   = b1.in_data;
    assign b2.in_valid  = b1.in_valid;
    assign b2.in_last   = b1.in_last;
    assign b2.in_op     = b1.in_op;
    assign b2.out_ready = b1.out_ready;

    typedef struct {
        logic [31:0] w0, w1, w2, w3;
        logic        opv;
        logic [63:0] a, b;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] d, input logic last, input logic opv);
        bit got = 1'b0;
        int n   = 0;
        b1.in_data  = d;
        b1.in_last  = last;
        b1.in_op    = opv;
        b1.in_valid = 1'b1;
        while (!got && n < 64) begin
            @(negedge clk);
            got = (b1.in_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        b1.in_valid = 1'b0;
        b1.in_last  = 1'b0;
        if (!got) chk("put_timeout", 64'd0, 64'd1);
    endtask

    task automatic put_frame(input logic [31:0] w0, w1, w2, w3, input logic opv, input bit gaps);
        logic [31:0] w[4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            put(w[i], (i == 3) ? 1'b1 : 1'b0, opv);
        end
    endtask

    task automatic check_out(input string name, input logic [63:0] ea, eb, input logic eop,
                             output int lat);
        int n = 0;
        @(negedge clk);
        while (b1.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        chk({name, "_valid"}, 64'(b1.out_valid), 64'd1);
        chk({name, "_A"}, b1.A, ea);
        chk({name, "_B"}, b1.B, eb);
        chk({name, "_op"}, 64'(b1.op), 64'(eop));
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, "_drop"}, 64'(b1.out_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(b1.out_valid), 64'd0);
        chk("rst_A", b1.A, 64'd0);
        chk("rst_B", b1.B, 64'd0);
        chk("rst_op", 64'(b1.op), 64'd0);
        chk("rst_in_ready", 64'(b1.in_ready), 64'd0);
        chk("rst_err_cnt", 64'(b1.err_cnt), 64'd0);
        chk("rst_frame_err", 64'(b1.frame_err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        logic [31:0] rw[4];
        logic        rop;

        vecs[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 1'b1,
                    64'h3F80000040000000, 64'h4040000040800000};
        vecs[1] = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 1'b0,
                    64'h00000000FFFFFFFF, 64'h8000000000000001};
        vecs[2] = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678, 32'h9ABCDEF0, 1'b1,
                    64'hDEADBEEFCAFEBABE, 64'h123456789ABCDEF0};

        b1.in_data = 32'd0; b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.in_op = 1'b0;
        b1.out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("idle_in_ready", 64'(b1.in_ready), 64'd1);
        @(posedge clk); #1;

        // Test 1: table of back-to-back frames with immediate consumption.
        for (int i = 0; i < 3; i++) begin
            put_frame(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3, vecs[i].opv, 1'b0);
            check_out($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].opv, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd0);
        end

        // Test 2: downstream back-pressure for 10 cycles.
        b1.out_ready = 1'b0;
        put_frame(vecs[0].w0, vecs[0].w1, vecs[0].w2, vecs[0].w3, 1'b1, 1'b0);
        b1.in_data = vecs[2].w0; b1.in_op = 1'b0; b1.in_last = 1'b0; b1.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_valid", 64'(b1.out_valid), 64'd1);
            chk("hold_A", b1.A, vecs[0].a);
            chk("hold_B", b1.B, vecs[0].b);
            chk("hold_in_ready", 64'(b1.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        b1.out_ready = 1'b1;
        @(negedge clk);
        chk("hs_in_ready", 64'(b1.in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_hs_in_ready", 64'(b1.in_ready), 64'd1);
        chk("post_hs_valid", 64'(b1.out_valid), 64'd0);
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        put(vecs[2].w1, 1'b0, 1'b1);
        put(vecs[2].w2, 1'b0, 1'b1);
        put(vecs[2].w3, 1'b1, 1'b1);
        check_out("bp_next", vecs[2].a, vecs[2].b, 1'b0, lat);

        // Test 3: early in_last on the 2nd word.
        do_reset();
        put(32'h11111111, 1'b0, 1'b1);
        put(32'h22222222, 1'b1, 1'b1);
        @(negedge clk);
        chk("short_frame_err", 64'(b1.frame_err), 64'd1);
        chk("short_err_cnt", 64'(b1.err_cnt), 64'd1);
        chk("short_no_valid", 64'(b1.out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("short_err_pulse", 64'(b1.frame_err), 64'd0);
        @(posedge clk); #1;
        put_frame(vecs[1].w0, vecs[1].w1, vecs[1].w2, vecs[1].w3, 1'b0, 1'b0);
        check_out("after_short", vecs[1].a, vecs[1].b, 1'b0, lat);

        // Test 4: 6-word burst, in_last only on the 6th word.
        do_reset();
        put(32'hA0000001, 1'b0, 1'b0);
        put(32'hA0000002, 1'b0, 1'b0);
        put(32'hA0000003, 1'b0, 1'b0);
        put(32'hA0000004, 1'b0, 1'b0);
        @(negedge clk);
        chk("long_frame_err", 64'(b1.frame_err), 64'd1);
        chk("long_no_valid", 64'(b1.out_valid), 64'd0);
        chk("long_err_cnt", 64'(b1.err_cnt), 64'd1);
        @(posedge clk); #1;
        put(32'hA0000005, 1'b0, 1'b1);
        put(32'hA0000006, 1'b1, 1'b1);
        @(negedge clk);
        chk("skip_no_err", 64'(b1.frame_err), 64'd0);
        chk("skip_err_cnt", 64'(b1.err_cnt), 64'd1);
        chk("skip_no_valid", 64'(b1.out_valid), 64'd0);
        @(posedge clk); #1;
        put_frame(vecs[2].w0, vecs[2].w1, vecs[2].w2, vecs[2].w3, 1'b1, 1'b0);
        check_out("after_skip", vecs[2].a, vecs[2].b, 1'b1, lat);

        // Test 5: random words with random in_valid gaps.
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < 4; k++) rw[k] = $urandom;
            rop = 1'($urandom_range(0, 1));
            put_frame(rw[0], rw[1], rw[2], rw[3], rop, 1'b1);
            check_out($sformatf("rand%0d", f), {rw[0], rw[1]}, {rw[2], rw[3]}, rop, lat);
        end

        // Test 6: reset mid-frame, then reset while holding.
        put(32'h55555555, 1'b0, 1'b1);
        put(32'h66666666, 1'b0, 1'b1);
        put(32'h77777777, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_A", b1.A, 64'd0);
        chk("midrst_B", b1.B, 64'd0);
        chk("midrst_op", 64'(b1.op), 64'd0);
        chk("midrst_in_ready", 64'(b1.in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        put_frame(vecs[0].w0, vecs[0].w1, vecs[0].w2, vecs[0].w3, 1'b1, 1'b0);
        check_out("after_midrst", vecs[0].a, vecs[0].b, 1'b1, lat);
        b1.out_ready = 1'b0;
        put_frame(vecs[1].w0, vecs[1].w1, vecs[1].w2, vecs[1].w3, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("holdrst_valid", 64'(b1.out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        b1.out_ready = 1'b1;
        @(negedge clk);
        chk("holdrst_in_ready", 64'(b1.in_ready), 64'd1);
        @(posedge clk); #1;

        // Test 7: counter saturation (2-bit counter instance).
        do_reset();
        for (int e = 0; e < 5; e++) begin
            put(32'hBAD00000 + 32'(e), 1'b1, 1'b0);
        end
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("sat_err_cnt2", 64'(b2.err_cnt), 64'd3);
        chk("sat_err_cnt8", 64'(b1.err_cnt), 64'd5);
        chk("sat_no_valid", 64'(b2.out_valid), 64'd0);
        @(posedge clk); #1;
        put(32'hBAD00009, 1'b1, 1'b0);
        @(negedge clk);
        chk("sat_hold_cnt2", 64'(b2.err_cnt), 64'd3);
        chk("sat_pulse_cnt2", 64'(b2.frame_err), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
